fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  core clock; all state changes on the rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 active  input  1  run enable from the core run-control FSM; 0 means no new fetches.
REQ-005 stall  input  1  pipeline stall; 1 blocks new request issue.
REQ-006 redirect_valid  input  1  branch/jump redirect strobe.
REQ-007 redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 00.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  word-aligned fetch address.
REQ-010 imem_gnt  input  1  request accepted this cycle.
REQ-011 imem_rvalid  input  1  read data valid; arrives 1 or more cycles after gnt.
REQ-012 imem_rdata  input  32  instruction word.
REQ-013 if_valid  output  1  if_pc/if_instr hold a valid instruction.
REQ-014 if_ready  input  1  decode accepts the instruction when if_valid & if_ready.
REQ-015 if_pc  output  32  PC of the presented instruction.
REQ-016 if_instr  output  32  presented instruction word.

Function
REQ-017 States: IDLE, REQ, WAIT, FULL.
REQ-018 IDLE -> REQ when active & !stall & output register free; a free output register is either empty or consumed this cycle.
REQ-019 REQ: imem_req=1 and imem_addr=pc.
REQ-020 In REQ, imem_req and imem_addr hold stable until imem_gnt; stall, inactivity and redirect never retract a pending request.
REQ-021 REQ -> WAIT on imem_gnt.
REQ-022 At most one request is outstanding at any time.
REQ-023 WAIT: on imem_rvalid, if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4.
REQ-024 The pc+4 increment wraps modulo 2^32.
REQ-025 After the WAIT capture, the next state is REQ if the REQ-018 conditions hold in that cycle, otherwise IDLE.
REQ-026 A captured instruction is presented on the cycle after imem_rvalid.
REQ-027 The output register is single-entry.
REQ-028 A response is accepted only when the output register is free, guaranteed by REQ-018; FULL covers a held, unconsumed instruction.
REQ-029 FULL -> REQ or IDLE on the handshake, per REQ-018.
REQ-030 if_valid drops on the handshake unless a new instruction is captured in the same cycle.
REQ-031 Redirect: pc<=redirect_pc & ~3 and if_valid<=0 in the same cycle.
REQ-032 Redirect in REQ before gnt, or in WAIT, sets kill.
REQ-033 A killed response is dropped: no capture and no pc update; kill then clears.
REQ-034 Redirect coincident with imem_rvalid: redirect wins and the response is dropped.
REQ-035 Redirect coincident with a handshake: the handshake completes, and the redirect still flushes.
REQ-036 active=0 while a request is outstanding: the request completes and its response is captured normally; no further requests are issued.
REQ-037 A redirect while in IDLE or FULL updates pc only.

Reset
REQ-038 On rstn=0, all of the following take effect immediately: state=IDLE, pc=RESET_PC, kill=0, if_valid=0, if_pc=0, if_instr=0, imem_req=0, imem_addr=RESET_PC.
REQ-039 Reset mid-transaction abandons the outstanding request.
REQ-040 Any imem_rvalid after reset release with no request outstanding is ignored.

Structure
REQ-041 Shared package holds: the state encoding (2-bit enum), the instruction width constant (32), and the NOP constant 32'h0000_0013.
REQ-042 The output register with its valid/ready logic is a natural sub-module: fetch_buf.

Verification
REQ-043 Scenario 1, single-cycle memory.
- Stimulus: active=1 one cycle after reset release, gnt immediate, rvalid 1 cycle after gnt, if_ready=1.
- Response: if_pc sequence 0,4,8,C with instructions matching memory.
REQ-044 Scenario 2, output backpressure.
- Stimulus: if_ready=0 for 5 cycles.
- Response: the FSM stays in FULL, if_instr is stable, and imem_req=0 for those cycles.
REQ-045 Scenario 3, redirect while waiting.
- Stimulus: redirect_pc=32'h100 in WAIT; rvalid with 32'hDEADBEEF arrives the next cycle.
- Response: DEADBEEF is never presented; the next if_pc is 0x100.
REQ-046 Scenario 4, request held before grant.
- Stimulus: gnt delayed 3 cycles while stall=1 rises mid-request.
- Response: imem_req and imem_addr are unchanged until gnt.
REQ-047 Scenario 5, inactive with a request in flight.
- Stimulus: active=0 while in WAIT.
- Response: the response is captured, followed by IDLE and no further imem_req.
REQ-048 Scenario 6, reset mid-transaction.
- Stimulus: rstn pulsed low in WAIT, followed by a stray rvalid.
- Response: if_valid=0, pc=RESET_PC, and the stray rvalid is ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } state_t;
endpackage

// File: rtl/fetch_unit_buf.sv
// fetch_buf: single-entry output register presenting fetched instructions to decode.
module fetch_buf
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            cap,
    input  logic            flush,
    input  logic [ILEN-1:0] cap_pc,
    input  logic [ILEN-1:0] cap_instr,
    input  logic            if_ready,
    output logic            if_valid,
    output logic [ILEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr,
    output logic            free
);
    // A capture never coincides with a flush; the fetch FSM drops responses on redirect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else if (cap) begin
            if_valid <= 1'b1;
            if_pc    <= cap_pc;
            if_instr <= cap_instr;
        end else if (flush || if_ready) begin
            if_valid <= 1'b0;
        end
    end

    assign free = !if_valid || if_ready;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with redirect and kill handling.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            active,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_pc,
    output logic [ILEN-1:0] if_instr
);
    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, addr;
    logic        kill, kill_nxt, free, go, resp, cap;

    assign resp = state == WAIT && imem_rvalid;
    assign cap  = resp && !kill && !redirect_valid;
    assign go   = active && !stall && free;

    always_comb begin
        pc_nxt    = redirect_valid ? (redirect_pc & ~32'd3) : cap ? pc + 32'd4 : pc;
        kill_nxt  = resp ? 1'b0 : (redirect_valid && (state == REQ || state == WAIT)) ? 1'b1 : kill;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = go ? REQ : IDLE;
            REQ:     state_nxt = imem_gnt ? WAIT : REQ;
            WAIT:    state_nxt = !imem_rvalid ? WAIT : cap ? FULL : go ? REQ : IDLE;
            FULL:    state_nxt = (free || redirect_valid) ? ((active && !stall) ? REQ : IDLE) : FULL;
            default: state_nxt = IDLE;
        endcase
    end

    // The request address is latched on REQ entry so a redirect cannot disturb a pending request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            pc    <= RESET_PC;
            kill  <= 1'b0;
            addr  <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            if (state_nxt == REQ && state != REQ)
                addr <= pc_nxt;
        end
    end

    assign imem_req  = state == REQ;
    assign imem_addr = addr;

    fetch_buf u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .cap       (cap),
        .flush     (redirect_valid),
        .cap_pc    (pc),
        .cap_instr (imem_rdata),
        .if_ready  (if_ready),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .free      (free)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario bench for fetch_unit.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk, rstn, active, stall, redirect_valid, imem_gnt, imem_rvalid, if_ready;
    logic        imem_req, if_valid;
    logic [31:0] redirect_pc, imem_rdata, imem_addr, if_pc, if_instr;
    int          n_tests, n_fail;
    logic        auto_mem, gnt_given;
    logic [31:0] resp_addr;
    int          wait_cnt, gnt_delay;

    fetch_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .active         (active),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction

    // Advance to the next falling edge; the optional memory model answers one cycle after grant.
    task automatic step();
        logic prev;
        @(negedge clk);
        if (auto_mem) begin
            prev        = gnt_given;
            gnt_given   = 1'b0;
            imem_gnt    = 1'b0;
            imem_rvalid = prev;
            imem_rdata  = prev ? mem_word(resp_addr) : 32'h0;
            if (imem_req) begin
                if (wait_cnt >= gnt_delay) begin
                    imem_gnt  = 1'b1;
                    gnt_given = 1'b1;
                    resp_addr = imem_addr;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; active = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        auto_mem = 1'b0; gnt_given = 1'b0; wait_cnt = 0; gnt_delay = 0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rstn = 1'b0;
        step();
        n_tests++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE); end
        n_tests++; if (dut.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", dut.pc); end
        n_tests++; if (dut.kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill: got %b want 0", dut.kill); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
        n_tests++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_regs: got pc=%h instr=%h want 0/0", if_pc, if_instr); end
        n_tests++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_imem: got req=%b addr=%h want 0/00000000", imem_req, imem_addr); end
        rstn = 1'b1;
    endtask

    task automatic test_single_cycle();
        logic [31:0] exp_pc;
        int got;
        do_reset();
        if_ready = 1'b1; auto_mem = 1'b1;
        step();
        active = 1'b1;
        exp_pc = 32'h0; got = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            step();
            if (if_valid && if_ready) begin
                n_tests++;
                if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL seq_fetch[%0d]: got pc=%h instr=%h want pc=%h instr=%h", got, if_pc, if_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4; got++;
            end
        end
        n_tests++; if (got != 4) begin n_fail++; $display("FAIL seq_fetch_count: got %0d want 4", got); end
        active = 1'b0;
    endtask

    task automatic test_backpressure();
        logic seen;
        do_reset();
        auto_mem = 1'b1;
        step();
        active = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            seen = if_valid;
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL bp_first_valid: got 0 want 1"); end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (dut.state !== FULL) begin n_fail++; $display("FAIL bp_state[%0d]: got %0d want %0d", i, dut.state, FULL); end
            n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0)) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h instr=%h want 1/00000000/%h", i, if_valid, if_pc, if_instr, mem_word(32'h0)); end
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_no_req[%0d]: got %b want 0", i, imem_req); end
            step();
        end
        if_ready = 1'b1;
        step();
        n_tests++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL bp_release: got v=%b req=%b addr=%h want 0/1/00000004", if_valid, imem_req, imem_addr); end
        active = 1'b0;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        if_ready = 1'b1;
        active = 1'b1;
        step();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rw_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        n_tests++; if (if_valid !== 1'b0 || if_instr === 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rw_dropped: got v=%b instr=%h want 0/not deadbeef", if_valid, if_instr); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL rw_refetch: got req=%b addr=%h want 1/00000100", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_rvalid = 1'b0;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL rw_target: got v=%b pc=%h instr=%h want 1/00000100/12345678", if_valid, if_pc, if_instr); end
        active = 1'b0;
    endtask

    task automatic test_req_hold();
        do_reset();
        active = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL hold_req[%0d]: got req=%b addr=%h want 1/00000000", i, imem_req, imem_addr); end
            if (i == 1) stall = 1'b1;
            if (i < 3) step();
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0011;
        step();
        imem_rvalid = 1'b0;
        n_tests++; if (dut.state !== FULL || if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h11) begin n_fail++; $display("FAIL hold_capture: got st=%0d v=%b pc=%h instr=%h want %0d/1/00000000/00000011", dut.state, if_valid, if_pc, if_instr, FULL); end
        if_ready = 1'b1;
        step();
        n_tests++; if (dut.state !== IDLE || imem_req !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL hold_stalled_idle: got st=%0d req=%b v=%b want %0d/0/0", dut.state, imem_req, if_valid, IDLE); end
    endtask

    task automatic test_inactive();
        do_reset();
        active = 1'b1;
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; active = 1'b0;
        step();
        n_tests++; if (dut.state !== WAIT || imem_req !== 1'b0) begin n_fail++; $display("FAIL inact_wait: got st=%0d req=%b want %0d/0", dut.state, imem_req, WAIT); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0000_0022;
        step();
        imem_rvalid = 1'b0;
        n_tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h22) begin n_fail++; $display("FAIL inact_capture: got v=%b pc=%h instr=%h want 1/00000000/00000022", if_valid, if_pc, if_instr); end
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL inact_no_req[%0d]: got %b want 0", i, imem_req); end
        end
        n_tests++; if (dut.state !== IDLE || if_valid !== 1'b0) begin n_fail++; $display("FAIL inact_idle: got st=%0d v=%b want %0d/0", dut.state, if_valid, IDLE); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        active = 1'b1;
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        step();
        imem_rvalid = 1'b0; if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL rm_second_req: got req=%b addr=%h want 1/00000004", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rstn = 1'b0;
        #1;
        n_tests++; if (dut.state !== IDLE || dut.pc !== 32'h0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async: got st=%0d pc=%h v=%b want %0d/00000000/0", dut.state, dut.pc, if_valid, IDLE); end
        n_tests++; if (if_instr !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_async_out: got instr=%h req=%b addr=%h want 0/0/0", if_instr, imem_req, imem_addr); end
        step();
        rstn = 1'b1; active = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        imem_rvalid = 1'b0;
        n_tests++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || dut.pc !== 32'h0 || dut.state !== IDLE) begin n_fail++; $display("FAIL rm_stray: got v=%b instr=%h pc=%h st=%0d want 0/0/0/%0d", if_valid, if_instr, dut.pc, dut.state, IDLE); end
    endtask

    task automatic test_wrap();
        int got;
        logic [31:0] exp_pc;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        n_tests++; if (dut.pc !== 32'hFFFF_FFFC || dut.state !== IDLE || imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_redirect: got pc=%h st=%0d req=%b want fffffffc/%0d/0", dut.pc, dut.state, imem_req, IDLE); end
        if_ready = 1'b1; auto_mem = 1'b1; active = 1'b1;
        exp_pc = 32'hFFFF_FFFC; got = 0;
        for (int c = 0; c < 30 && got < 2; c++) begin
            step();
            if (if_valid && if_ready) begin
                n_tests++;
                if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
                    n_fail++;
                    $display("FAIL wrap[%0d]: got pc=%h instr=%h want pc=%h instr=%h", got, if_pc, if_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4; got++;
            end
        end
        n_tests++; if (got != 2) begin n_fail++; $display("FAIL wrap_count: got %0d want 2", got); end
        active = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        test_reset();
        test_single_cycle();
        test_backpressure();
        test_redirect_wait();
        test_req_hold();
        test_inactive();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
